// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with valid/ready handshakes on input and output and a sticky overflow flag.
module binary_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int CW     = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [WIDTH-1:0]      r_bin;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_ovf;
  logic [CW-1:0]         r_count;

  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_shift_bcd;
  logic                  w_shift_out;
  logic                  w_last;

  // Add-3 correction per digit; the 4-bit sum never carries since digits are <= 9.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_shift_bcd = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
  assign w_shift_out = w_adj[4*DIGITS-1];
  assign w_last      = (r_count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath registers only move on an accepted input or during SHIFT, so
  // the result stays frozen through DONE regardless of the input pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bin   <= in;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_count <= CW'(WIDTH);
          end
        end
        S_SHIFT: begin
          r_bin   <= r_bin << 1;
          r_bcd   <= w_shift_bcd;
          r_ovf   <= r_ovf | w_shift_out;
          r_count <= r_count - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bcd      = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed and swept checks of binary_to_bcd_seq across four WIDTH/DIGITS
// configurations sharing one clock, reset and stimulus bus.
module tb_binary_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] inBus;
  logic        inValid;
  logic        outReady;
  int          sel;

  int vectorCount;
  int miscompares;

  // Per-instance handshake gating so only the selected converter sees requests
  logic        validA, validB, validC, validD;
  logic        readyOutA, readyOutB, readyOutC, readyOutD;
  logic        inReadyA, inReadyB, inReadyC, inReadyD;
  logic [11:0] bcdA;
  logic [19:0] bcdB;
  logic [7:0]  bcdC;
  logic [3:0]  bcdD;
  logic        ovfA, ovfB, ovfC, ovfD;
  logic        outValidA, outValidB, outValidC, outValidD;
  logic        busyA, busyB, busyC, busyD;

  assign validA    = inValid  && (sel == 0);
  assign validB    = inValid  && (sel == 1);
  assign validC    = inValid  && (sel == 2);
  assign validD    = inValid  && (sel == 3);
  assign readyOutA = outReady && (sel == 0);
  assign readyOutB = outReady && (sel == 1);
  assign readyOutC = outReady && (sel == 2);
  assign readyOutD = outReady && (sel == 3);

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dutA (
    .clk(clk), .rst_n(rst_n), .in(inBus[7:0]), .in_valid(validA), .in_ready(inReadyA),
    .bcd(bcdA), .overflow(ovfA), .out_valid(outValidA), .out_ready(readyOutA), .busy(busyA)
  );

  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dutB (
    .clk(clk), .rst_n(rst_n), .in(inBus[15:0]), .in_valid(validB), .in_ready(inReadyB),
    .bcd(bcdB), .overflow(ovfB), .out_valid(outValidB), .out_ready(readyOutB), .busy(busyB)
  );

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dutC (
    .clk(clk), .rst_n(rst_n), .in(inBus[7:0]), .in_valid(validC), .in_ready(inReadyC),
    .bcd(bcdC), .overflow(ovfC), .out_valid(outValidC), .out_ready(readyOutC), .busy(busyC)
  );

  binary_to_bcd_seq #(.WIDTH(1), .DIGITS(1)) dutD (
    .clk(clk), .rst_n(rst_n), .in(inBus[0:0]), .in_valid(validD), .in_ready(inReadyD),
    .bcd(bcdD), .overflow(ovfD), .out_valid(outValidD), .out_ready(readyOutD), .busy(busyD)
  );

  // Observation mux: everything below looks only at the selected instance
  logic [39:0] obsBcd;
  logic        obsOvf, obsValid, obsBusy, obsInReady;

  always_comb begin
    obsBcd     = '0;
    obsOvf     = 1'b0;
    obsValid   = 1'b0;
    obsBusy    = 1'b0;
    obsInReady = 1'b0;
    case (sel)
      0: begin obsBcd = {28'd0, bcdA}; obsOvf = ovfA; obsValid = outValidA; obsBusy = busyA; obsInReady = inReadyA; end
      1: begin obsBcd = {20'd0, bcdB}; obsOvf = ovfB; obsValid = outValidB; obsBusy = busyB; obsInReady = inReadyB; end
      2: begin obsBcd = {32'd0, bcdC}; obsOvf = ovfC; obsValid = outValidC; obsBusy = busyC; obsInReady = inReadyC; end
      default: begin obsBcd = {36'd0, bcdD}; obsOvf = ovfD; obsValid = outValidD; obsBusy = busyD; obsInReady = inReadyD; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miscompare
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int widthOf(input int s);
    case (s)
      0: return 8;
      1: return 16;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  // Reference: decimal digits of val modulo 10^digits, plus overflow flag
  function automatic logic [40:0] refBcd(input logic [31:0] val, input int digits);
    logic [39:0] res;
    longint      v;
    longint      lim;
    res = '0;
    v   = longint'(val);
    lim = 1;
    for (int d = 0; d < digits; d++) lim = lim * 10;
    for (int d = 0; d < digits; d++) begin
      res[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {(longint'(val) >= lim), res};
  endfunction

  // One full transaction: handshake, wait for result, optional stall, release
  task automatic applyStimulus(input int s, input logic [31:0] val, input int stall,
                               input bit chkBusy, input logic [39:0] expBcd, input logic expOvf);
    int          cycles;
    logic [39:0] heldBcd;
    logic        heldOvf;
    sel     = s;
    inBus   = val;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = (stall > 0);
    inBus   = val ^ 32'hA5A5_5A5A;
    cycles  = 0;
    while (!obsValid && cycles < 100) begin
      if (chkBusy) begin
        checkOutput("busy_in_shift", 64'(obsBusy), 64'd1);
        checkOutput("in_ready_in_shift", 64'(obsInReady), 64'd0);
      end
      @(posedge clk); #1;
      cycles++;
      inBus = $urandom;
    end
    checkOutput($sformatf("latency_%0d", val), 64'(cycles), 64'(widthOf(s)));
    checkOutput($sformatf("bcd_%0d", val), 64'(obsBcd), 64'(expBcd));
    checkOutput($sformatf("ovf_%0d", val), 64'(obsOvf), 64'(expOvf));
    heldBcd = obsBcd;
    heldOvf = obsOvf;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      inBus = $urandom;
      checkOutput("stall_valid", 64'(obsValid), 64'd1);
      checkOutput("stall_bcd", 64'(obsBcd), 64'(heldBcd));
      checkOutput("stall_ovf", 64'(obsOvf), 64'(heldOvf));
      checkOutput("stall_in_ready", 64'(obsInReady), 64'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput("post_ack_in_ready", 64'(obsInReady), 64'd1);
    checkOutput("post_ack_valid", 64'(obsValid), 64'd0);
  endtask

  // Sweep helper: expected values come from the decimal reference model
  task automatic applyModelled(input int s, input logic [31:0] val, input int digits, input int stall);
    logic [40:0] r;
    r = refBcd(val, digits);
    applyStimulus(s, val, stall, 1'b0, r[39:0], r[40]);
  endtask

  initial begin
    vectorCount = 0;
    miscompares = 0;
    sel         = 0;
    inBus       = '0;
    inValid     = 1'b0;
    outReady    = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(obsInReady), 64'd1);
    checkOutput("reset_out_valid", 64'(obsValid), 64'd0);
    checkOutput("reset_busy", 64'(obsBusy), 64'd0);
    checkOutput("reset_bcd", 64'(obsBcd), 64'd0);
    checkOutput("reset_ovf", 64'(obsOvf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 255, 0, 1'b1, 40'h255, 1'b0);
    applyStimulus(1, 65535, 0, 1'b1, 40'h65535, 1'b0);
    applyStimulus(1, 0, 0, 1'b0, 40'h00000, 1'b0);
    applyStimulus(1, 10000, 0, 1'b0, 40'h10000, 1'b0);
    applyStimulus(1, 12345, 0, 1'b0, 40'h12345, 1'b0);
    applyStimulus(2, 99, 0, 1'b0, 40'h99, 1'b0);
    applyStimulus(2, 100, 0, 1'b0, 40'h00, 1'b1);
    applyStimulus(2, 255, 0, 1'b0, 40'h55, 1'b1);
    applyStimulus(3, 1, 0, 1'b1, 40'h1, 1'b0);
    applyStimulus(3, 0, 0, 1'b0, 40'h0, 1'b0);
    applyStimulus(0, 198, 5, 1'b0, 40'h198, 1'b0);

    // Abort mid-conversion: four shifts done, count reads 4
    sel     = 0;
    inBus   = 200;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", 64'(obsBusy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 64'(obsInReady), 64'd1);
    checkOutput("abort_out_valid", 64'(obsValid), 64'd0);
    checkOutput("abort_bcd", 64'(obsBcd), 64'd0);
    checkOutput("abort_busy", 64'(obsBusy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 37, 0, 1'b0, 40'h037, 1'b0);

    for (int v = 0; v < 256; v++) begin
      applyModelled(0, 32'(v), 3, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
